ctrl_cfg_pkt_gen: RTL and testbench

- Control-path packet initiator for the RMT pipeline.
- Turns simple table-write requests (stage, action/module slot, index, 16-bit entry) into 3-beat 256-bit control AXI-Stream packets.
- Each packet is formatted so an action engine's control path recognises it, captures the index and writes the entry into its page table.
- Sits at the head of the control daisy chain, typically behind a host/CPU register interface. It drives the chain's c_s_axis inputs, which carry no tready.

---
 rtl/ctrl_cfg_pkt_gen_if.sv | 33 +++
 rtl/ctrl_cfg_pkt_gen.sv | 187 ++++++++++++++++++
 tb/tb_ctrl_cfg_pkt_gen.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_cfg_pkt_gen_if.sv
// Request and control-stream bundle for ctrl_cfg_pkt_gen.
// master = the packet generator, slave = the host/chain side.
interface ctrl_cfg_pkt_gen_if #(
    parameter int DATA_W = 256,
    parameter int USER_W = 128
);
    logic                  req_valid;
    logic                  req_ready;
    logic [4:0]            req_stage_id;
    logic [2:0]            req_action_id;
    logic [7:0]            req_index;
    logic [15:0]           req_data;

    logic [DATA_W-1:0]     c_m_axis_tdata;
    logic [USER_W-1:0]     c_m_axis_tuser;
    logic [DATA_W/8-1:0]   c_m_axis_tkeep;
    logic                  c_m_axis_tvalid;
    logic                  c_m_axis_tlast;

    modport master (
        input  req_valid, req_stage_id, req_action_id, req_index, req_data,
        output req_ready,
        output c_m_axis_tdata, c_m_axis_tuser, c_m_axis_tkeep,
        output c_m_axis_tvalid, c_m_axis_tlast
    );

    modport slave (
        output req_valid, req_stage_id, req_action_id, req_index, req_data,
        input  req_ready,
        input  c_m_axis_tdata, c_m_axis_tuser, c_m_axis_tkeep,
        input  c_m_axis_tvalid, c_m_axis_tlast
    );
endinterface

// File: rtl/ctrl_cfg_pkt_gen.sv
// Turns table-write requests into 3-beat 256-bit control packets for the RMT chain.
// Optional: define CTRL_CFG_PKT_GEN_CNT_EN to add the pkt_cnt tlast counter output.
module ctrl_cfg_pkt_gen #(
    parameter int                               C_S_AXIS_DATA_WIDTH  = 256,
    parameter int                               C_S_AXIS_TUSER_WIDTH = 128,
    parameter int                               REQ_FIFO_DEPTH       = 4,
    parameter int                               GAP_CYCLES           = 2,
    parameter logic [C_S_AXIS_DATA_WIDTH-1:0]   HDR_BEAT0            = '0,
    parameter logic [15:0]                      PKT_LEN_BYTES        = 16'd96
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ctrl_cfg_pkt_gen_if.master   bus,
`ifdef CTRL_CFG_PKT_GEN_CNT_EN
    output logic [31:0]          pkt_cnt,
`endif
    output logic                 busy
);

    localparam int KEEP_W = C_S_AXIS_DATA_WIDTH / 8;
    localparam int ADDR_W = $clog2(REQ_FIFO_DEPTH);
    localparam int GW     = $clog2(GAP_CYCLES + 1);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(REQ_FIFO_DEPTH);
    localparam logic [GW-1:0]   GAP_LOAD = GW'(GAP_CYCLES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_BEAT0 = 3'd1;
    localparam logic [2:0] S_BEAT1 = 3'd2;
    localparam logic [2:0] S_BEAT2 = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    typedef struct packed {
        logic [4:0]  stage;
        logic [2:0]  action;
        logic [7:0]  index;
        logic [15:0] data;
    } req_t;

    req_t                r_mem [REQ_FIFO_DEPTH];
    logic [ADDR_W-1:0]   r_wptr;
    logic [ADDR_W-1:0]   r_rptr;
    logic [ADDR_W:0]     r_count;
    logic                r_ready;
    req_t                r_hold;
    logic [2:0]          r_state;
    logic [GW-1:0]       r_gap;

    logic [C_S_AXIS_DATA_WIDTH-1:0]  r_tdata;
    logic [C_S_AXIS_TUSER_WIDTH-1:0] r_tuser;
    logic [KEEP_W-1:0]               r_tkeep;
    logic                            r_tvalid;
    logic                            r_tlast;

    logic                            w_push;
    logic                            w_pop;
    logic [ADDR_W:0]                 w_count_nxt;
    logic [2:0]                      w_state_nxt;
    logic [C_S_AXIS_DATA_WIDTH-1:0]  w_tdata;
    logic [C_S_AXIS_TUSER_WIDTH-1:0] w_tuser;
    logic [KEEP_W-1:0]               w_tkeep;
    logic                            w_tvalid;
    logic                            w_tlast;

    assign w_push = bus.req_valid && r_ready;
    assign w_pop  = (r_state == S_IDLE) && (r_count != '0);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + (ADDR_W + 1)'(1);
            2'b01:   w_count_nxt = r_count - (ADDR_W + 1)'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage needs no reset: pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= {bus.req_stage_id, bus.req_action_id, bus.req_index, bus.req_data};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ready <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + ADDR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + ADDR_W'(1);
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt != FULL_CNT);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (r_count != '0) w_state_nxt = S_BEAT0;
            S_BEAT0: w_state_nxt = S_BEAT1;
            S_BEAT1: w_state_nxt = S_BEAT2;
            S_BEAT2: w_state_nxt = S_GAP;
            S_GAP:   if (r_gap == '0) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so each beat is registered alongside its state.
    always_comb begin
        w_tdata  = '0;
        w_tuser  = '0;
        w_tkeep  = '0;
        w_tvalid = 1'b0;
        w_tlast  = 1'b0;
        case (w_state_nxt)
            S_BEAT0: begin
                w_tdata        = HDR_BEAT0;
                w_tuser[15:0]  = PKT_LEN_BYTES;
                w_tkeep        = '1;
                w_tvalid       = 1'b1;
            end
            S_BEAT1: begin
                w_tdata[79:64]   = 16'hf2f1;
                w_tdata[119:112] = {r_hold.stage, r_hold.action};
                w_tdata[135:128] = r_hold.index;
                w_tkeep          = '1;
                w_tvalid         = 1'b1;
            end
            S_BEAT2: begin
                // Byte-swapped so the receiver's swap restores the entry.
                w_tdata[7:0]   = r_hold.data[15:8];
                w_tdata[15:8]  = r_hold.data[7:0];
                w_tkeep        = '1;
                w_tvalid       = 1'b1;
                w_tlast        = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_gap    <= '0;
            r_hold   <= '0;
            r_tdata  <= '0;
            r_tuser  <= '0;
            r_tkeep  <= '0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_BEAT2)
                r_gap <= GAP_LOAD;
            else if (r_state == S_GAP && r_gap != '0)
                r_gap <= r_gap - GW'(1);
            if (w_pop) r_hold <= r_mem[r_rptr];
            r_tdata  <= w_tdata;
            r_tuser  <= w_tuser;
            r_tkeep  <= w_tkeep;
            r_tvalid <= w_tvalid;
            r_tlast  <= w_tlast;
        end
    end

`ifdef CTRL_CFG_PKT_GEN_CNT_EN
    logic [31:0] r_pkt_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_pkt_cnt <= '0;
        else if (r_tvalid && r_tlast)
            r_pkt_cnt <= r_pkt_cnt + 32'd1;
    end

    assign pkt_cnt = r_pkt_cnt;
`endif

    assign bus.req_ready       = r_ready;
    assign bus.c_m_axis_tdata  = r_tdata;
    assign bus.c_m_axis_tuser  = r_tuser;
    assign bus.c_m_axis_tkeep  = r_tkeep;
    assign bus.c_m_axis_tvalid = r_tvalid;
    assign bus.c_m_axis_tlast  = r_tlast;
    assign busy                = (r_count != '0) || (r_state != S_IDLE);

endmodule

// File: tb/tb_ctrl_cfg_pkt_gen.sv
// Scoreboard bench for ctrl_cfg_pkt_gen: packets and start times predicted from the request stream.
module tb_ctrl_cfg_pkt_gen;
    localparam int GAP = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
`ifdef CTRL_CFG_PKT_GEN_CNT_EN
    logic [31:0] pkt_cnt;
`endif

    always #5 clk = ~clk;

    ctrl_cfg_pkt_gen_if bus ();

    ctrl_cfg_pkt_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
`ifdef CTRL_CFG_PKT_GEN_CNT_EN
        .pkt_cnt (pkt_cnt),
`endif
        .busy  (busy)
    );

    typedef struct {
        logic [255:0] d;
        logic [127:0] u;
        logic [31:0]  k;
        logic         l;
        bit           first;
        int           acc;
    } beat_t;

    beat_t expq[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_tlast = -1000;
    int pkts_since_rst = 0;
    bit mid = 0;

    function automatic void chk(string nm, logic [255:0] act, logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Reference: a packet is header, then address beat, then byte-swapped data.
    function automatic void model_push(logic [4:0] s, logic [2:0] a, logic [7:0] ix,
                                       logic [15:0] dat, int acc);
        beat_t b;
        int swapped;
        b.d = '0; b.u = 128'd96; b.k = '1; b.l = 1'b0; b.first = 1'b1; b.acc = acc;
        expq.push_back(b);
        b.d = (256'h0f2f1 << 64) | (256'(int'(s) * 8 + int'(a)) << 112) | (256'(ix) << 128);
        b.u = '0; b.first = 1'b0;
        expq.push_back(b);
        swapped = (int'(dat) % 256) * 256 + int'(dat) / 256;
        b.d = 256'(swapped); b.l = 1'b1;
        expq.push_back(b);
    endfunction

    always @(negedge clk) begin
        beat_t e;
        int exp0;
        cyc++;
        if (bus.c_m_axis_tvalid) begin
            if (expq.size() == 0) begin
                chk("unexpected_beat", 1'b1, 1'b0);
            end else begin
                e = expq.pop_front();
                chk("tdata", bus.c_m_axis_tdata, e.d);
                chk("tuser", bus.c_m_axis_tuser, e.u);
                chk("tkeep", bus.c_m_axis_tkeep, e.k);
                chk("tlast", bus.c_m_axis_tlast, e.l);
                if (e.first) begin
                    exp0 = (e.acc + 2 > last_tlast + GAP + 2) ? e.acc + 2 : last_tlast + GAP + 2;
                    chk("beat0_cycle", 256'(cyc), 256'(exp0));
                end
            end
            if (bus.c_m_axis_tlast) begin
                last_tlast = cyc;
                pkts_since_rst++;
                mid = 1'b0;
            end else begin
                mid = 1'b1;
            end
        end else begin
            if (mid) chk("bubble_in_packet", 1'b0, 1'b1);
            mid = 1'b0;
            chk("idle_outputs_zero", |{bus.c_m_axis_tdata, bus.c_m_axis_tuser,
                                       bus.c_m_axis_tkeep, bus.c_m_axis_tlast}, 1'b0);
        end
        if (!rst_n) begin
            expq.delete();
            mid = 1'b0;
            last_tlast = -1000;
            pkts_since_rst = 0;
        end else if (bus.req_valid && bus.req_ready) begin
            model_push(bus.req_stage_id, bus.req_action_id, bus.req_index, bus.req_data, cyc);
        end
    end

    task automatic send(input logic [4:0] s, input logic [2:0] a, input logic [7:0] ix,
                        input logic [15:0] dat, output bit stalled);
        bit ok;
        ok = 1'b0;
        stalled = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_stage_id = s;
        bus.req_action_id = a;
        bus.req_index = ix;
        bus.req_data = dat;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                ok = 1'b1;
                break;
            end
            stalled = 1'b1;
        end
        chk("send_accept", ok, 1'b1);
    endtask

    task automatic send_rand(output bit stalled);
        send(5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)),
             8'($urandom_range(0, 255)), 16'($urandom_range(0, 65535)), stalled);
    endtask

    task automatic drop;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic drain;
        bit done;
        done = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (expq.size() == 0 && !busy) begin
                done = 1'b1;
                break;
            end
        end
        chk("drain", done, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bit st;
        bit any_st;
        bit seen;
        bus.req_valid = 1'b0;
        bus.req_stage_id = '0;
        bus.req_action_id = '0;
        bus.req_index = '0;
        bus.req_data = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tvalid", bus.c_m_axis_tvalid, 1'b0);
        chk("rst_tdata", bus.c_m_axis_tdata, 256'd0);
        chk("rst_busy", busy, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("ready_after_rst", bus.req_ready, 1'b1);
        chk("busy_idle", busy, 1'b0);

        // Single request latency and field placement.
        send(5'd3, 3'd3, 8'h05, 16'hABCD, st);
        @(posedge clk); #1 bus.req_valid = 1'b0;
        @(negedge clk);
        chk("t1_tvalid_low", bus.c_m_axis_tvalid, 1'b0);
        chk("t1_busy", busy, 1'b1);
        @(negedge clk);
        chk("t2_beat0_valid", bus.c_m_axis_tvalid, 1'b1);
        chk("t2_pkt_len", bus.c_m_axis_tuser[15:0], 16'd96);
        @(negedge clk);
        chk("t3_magic", bus.c_m_axis_tdata[79:64], 16'hf2f1);
        chk("t3_mod_id", bus.c_m_axis_tdata[119:112], 8'h1B);
        chk("t3_index", bus.c_m_axis_tdata[135:128], 8'h05);
        @(negedge clk);
        chk("t4_data", bus.c_m_axis_tdata[15:0], 16'hCDAB);
        chk("t4_tlast", bus.c_m_axis_tlast, 1'b1);
        drain();

        // Back-to-back burst fills the FIFO and must back-pressure.
        any_st = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send_rand(st);
            any_st |= st;
        end
        drop();
        chk("backpressure_seen", any_st, 1'b1);
        drain();

        // Longer burst: full-with-pop and pointer wrap.
        for (int i = 0; i < 12; i++) send_rand(st);
        drop();
        drain();

        // Reset while BEAT1 is registered.
        send_rand(st);
        drop();
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.c_m_axis_tvalid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rst_mid_beat0_seen", seen, 1'b1);
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_tvalid", bus.c_m_axis_tvalid, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;
        send(5'd31, 3'd7, 8'hFF, 16'h00FF, st);
        drop();
        drain();

        // Random traffic with random idle gaps.
        for (int i = 0; i < 40; i++) begin
            send_rand(st);
            if ($urandom_range(0, 1) == 1) begin
                drop();
                repeat ($urandom_range(0, 8)) @(posedge clk);
            end
        end
        drop();
        drain();

`ifdef CTRL_CFG_PKT_GEN_CNT_EN
        chk("pkt_cnt", pkt_cnt, 256'(pkts_since_rst));
        @(negedge clk);
        force dut.r_pkt_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.r_pkt_cnt;
        send_rand(st);
        drop();
        drain();
        chk("pkt_cnt_wrap", pkt_cnt, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
